systolic_sequencer: RTL and testbench

//  Sequences one systolic_array instance (weight-stationary, data flows along rows, partial sums flow down columns).

---
 rtl/sa_pkg.sv | 23 ++
 rtl/delay_line.sv | 39 +++
 rtl/systolic_sequencer.sv | 130 +++++++++++++
 tb/tb_systolic_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
`default_nettype none
// ============================================================================
// Module : sa_pkg
// Brief  : Shared types and constants for the systolic array sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package sa_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    // Handshake-to-result latency of the skew + array + deskew path
    function automatic int sa_lat(input int n);
        return 2 * n - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/delay_line.sv
`default_nettype none
// ============================================================================
// Module : delay_line
// Brief  : DEPTH-stage register delay; DEPTH=0 degenerates to a wire.
// Rev    : 1.0  initial release
// ============================================================================
module delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic w_unused;
            assign w_unused = clk ^ reset;
            assign q        = d;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < DEPTH; k++) r_stage[k] <= '0;
                end else begin
                    r_stage[0] <= d;
                    for (int k = 1; k < DEPTH; k++) r_stage[k] <= r_stage[k-1];
                end
            end

            assign q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/systolic_sequencer.sv
`default_nettype none
// ============================================================================
// Module : systolic_sequencer
// Brief  : Weight-tile latch, input skew, output deskew and stream FSM for a
//          weight-stationary systolic array.
// Rev    : 1.0  initial release
// ============================================================================
module systolic_sequencer #(
    parameter int ARRAY_SIZE = 9,
    parameter int DATA_W     = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   cfg_w_valid,
    output logic                                   cfg_w_ready,
    input  logic [DATA_W*ARRAY_SIZE*ARRAY_SIZE-1:0] cfg_w_data,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [DATA_W*ARRAY_SIZE-1:0]            in_data,
    input  logic                                   in_last,
    output logic [DATA_W*ARRAY_SIZE-1:0]            sa_datain,
    output logic [DATA_W*ARRAY_SIZE*ARRAY_SIZE-1:0] sa_weightin,
    input  logic [DATA_W*ARRAY_SIZE-1:0]            sa_macout,
    output logic                                   out_valid,
    output logic [DATA_W*ARRAY_SIZE-1:0]            out_data,
    output logic                                   busy,
    output logic                                   done
);
    import sa_pkg::*;

    localparam int N     = ARRAY_SIZE;
    localparam int LAT   = sa_lat(N);
    localparam int CNT_W = $clog2(2 * N);
    localparam logic [CNT_W-1:0] c_lat_cnt = CNT_W'(LAT);
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

    state_t                      r_state;
    logic                        r_w_loaded;
    logic [DATA_W*N*N-1:0]       r_weight;
    logic [DATA_W*N-1:0]         r_in_reg;
    logic [LAT-1:0]              r_valid_pipe;
    logic                        r_out_valid;
    logic                        r_done;
    logic [CNT_W-1:0]            r_cnt;
    logic [DATA_W*N-1:0]         w_deskew;
    logic                        w_cfg_fire;
    logic                        w_in_fire;

    assign cfg_w_ready = (r_state == IDLE);
    assign in_ready    = (r_state == STREAM) | ((r_state == IDLE) & r_w_loaded);
    assign w_cfg_fire  = cfg_w_valid & cfg_w_ready;
    assign w_in_fire   = in_valid & in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_w_loaded   <= 1'b0;
            r_weight     <= '0;
            r_in_reg     <= '0;
            r_valid_pipe <= '0;
            r_out_valid  <= 1'b0;
            r_done       <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_done       <= 1'b0;
            // Idle cycles inject an all-zero bubble so nothing stale reaches the array
            r_in_reg     <= w_in_fire ? in_data : '0;
            r_valid_pipe <= {r_valid_pipe[LAT-2:0], w_in_fire};
            // Extra stage lines the valid bit up with the unregistered last deskew lane
            r_out_valid  <= r_valid_pipe[LAT-1];

            case (r_state)
                IDLE: begin
                    if (w_cfg_fire) begin
                        r_weight   <= cfg_w_data;
                        r_w_loaded <= 1'b1;
                    end
                    if (w_in_fire) begin
                        r_cnt   <= '0;
                        r_state <= in_last ? DRAIN : STREAM;
                    end
                end
                STREAM: begin
                    if (w_in_fire && in_last) begin
                        r_cnt   <= '0;
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (r_cnt == c_lat_cnt) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_skew
            delay_line #(.DEPTH(gi), .WIDTH(DATA_W)) u_skew (
                .clk   (clk),
                .reset (reset),
                .d     (r_in_reg[gi*DATA_W +: DATA_W]),
                .q     (sa_datain[gi*DATA_W +: DATA_W])
            );
        end

        for (gi = 0; gi < N; gi++) begin : g_deskew
            delay_line #(.DEPTH(N - 1 - gi), .WIDTH(DATA_W)) u_deskew (
                .clk   (clk),
                .reset (reset),
                .d     (sa_macout[gi*DATA_W +: DATA_W]),
                .q     (w_deskew[gi*DATA_W +: DATA_W])
            );
        end
    endgenerate

    assign sa_weightin = r_weight;
    assign out_valid   = r_out_valid;
    assign out_data    = {(DATA_W*N){r_out_valid}} & w_deskew;
    assign busy        = (r_state != IDLE);
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_systolic_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_systolic_sequencer
// Brief  : Scoreboard bench for systolic_sequencer (N=3) with a behavioural
//          weight-stationary array attached.
// Rev    : 1.0  initial release
// ============================================================================
module tb_systolic_sequencer;

    localparam int N   = 3;
    localparam int LAT = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_w_valid;
    logic          cfg_w_ready;
    logic [71:0]   cfg_w_data;
    logic          in_valid;
    logic          in_ready;
    logic [23:0]   in_data;
    logic          in_last;
    logic [23:0]   sa_datain;
    logic [71:0]   sa_weightin;
    logic [23:0]   sa_macout;
    logic          out_valid;
    logic [23:0]   out_data;
    logic          busy;
    logic          done;

    systolic_sequencer #(.ARRAY_SIZE(N), .DATA_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_w_valid (cfg_w_valid),
        .cfg_w_ready (cfg_w_ready),
        .cfg_w_data  (cfg_w_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .sa_datain   (sa_datain),
        .sa_weightin (sa_weightin),
        .sa_macout   (sa_macout),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Behavioural array: data moves right, partial sums move down, 1-cycle PEs
    logic [7:0] pa [N][N];
    logic [7:0] pc [N][N];
    logic [7:0] ain [N][N+1];
    logic [7:0] cin [N+1][N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ain[i][0] = sa_datain[i*8 +: 8];
            for (int j = 0; j < N; j++) ain[i][j+1] = pa[i][j];
        end
        for (int j = 0; j < N; j++) begin
            cin[0][j] = 8'd0;
            for (int i = 0; i < N; i++) cin[i+1][j] = pc[i][j];
        end
        sa_macout = '0;
        for (int j = 0; j < N; j++) sa_macout[j*8 +: 8] = cin[N][j];
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    pa[i][j] <= 8'd0;
                    pc[i][j] <= 8'd0;
                end
        end else begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    pa[i][j] <= ain[i][j];
                    pc[i][j] <= cin[i][j] + ain[i][j] * sa_weightin[(i*N+j)*8 +: 8];
                end
        end
    end

    typedef struct {
        logic [23:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          cyc = 0;
    int          exp_done_cyc = -1;
    int          n_vec = 0;
    int          n_err = 0;
    logic [71:0] tb_w = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [23:0] model(input logic [23:0] v, input logic [71:0] w);
        logic [23:0] r;
        r = '0;
        for (int j = 0; j < N; j++) begin
            logic [7:0] acc;
            acc = 8'd0;
            for (int i = 0; i < N; i++) acc = acc + v[i*8 +: 8] * w[(i*N+j)*8 +: 8];
            r[j*8 +: 8] = acc;
        end
        return r;
    endfunction

    // Output monitor: compares against the scoreboard and the expected done cycle
    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) chk("spurious_out_valid", 1, 0);
            else begin
                e = sb.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_cycle", cyc, e.due);
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            chk("out_missing", 0, 1);
            void'(sb.pop_front());
        end
        if (done || (exp_done_cyc >= 0 && cyc >= exp_done_cyc)) begin
            chk("done_cycle", done ? cyc : -1, exp_done_cyc);
            exp_done_cyc = -1;
        end
    end

    // While a tile is being offered mid-stream it must be refused and the old one held
    always @(negedge clk) begin
        if (cfg_w_valid && busy && !reset) begin
            chk("cfg_ready_busy", cfg_w_ready, 0);
            chk("weight_hold", sa_weightin, tb_w);
        end
    end

    task automatic load_tile(input logic [71:0] t);
        cfg_w_valid = 1'b1;
        cfg_w_data  = t;
        chk("cfg_ready_idle", cfg_w_ready, 1);
        @(negedge clk);
        cfg_w_valid = 1'b0;
        tb_w = t;
        chk("weightin", sa_weightin, t);
    endtask

    task automatic drive_vec(input logic [23:0] v, input bit last);
        in_valid = 1'b1;
        in_data  = v;
        in_last  = last;
        chk("in_ready", in_ready, 1);
        sb.push_back('{data: model(v, tb_w), due: cyc + 1 + LAT});
        if (last) exp_done_cyc = cyc + 1 + LAT + 1;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 60; k++) begin
            if (!busy && sb.size() == 0 && exp_done_cyc < 0) break;
            if (done) cfg_w_valid = 1'b0;
            @(negedge clk);
        end
        if (k == 60) chk("drain_timeout", 0, 1);
        cfg_w_valid = 1'b0;
    endtask

    logic [23:0] stream_v [4];

    initial begin
        stream_v[0] = {8'd1, 8'd1, 8'd1};
        stream_v[1] = {8'd2, 8'd2, 8'd2};
        stream_v[2] = {8'd0, 8'd0, 8'd3};
        stream_v[3] = {8'd5, 8'd0, 8'd0};

        reset = 1'b1;
        cfg_w_valid = 1'b0; cfg_w_data = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy_done", {busy, done}, 0);
        chk("rst_sa_datain", sa_datain, 0);
        chk("rst_sa_weightin", sa_weightin, 0);
        chk("rst_out_data", out_data, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_cfg_ready", cfg_w_ready, 1);
        chk("idle_in_ready_unloaded", in_ready, 0);

        // Identity tile, single vector
        load_tile(72'h01_00_00_00_01_00_00_00_01);
        drive_vec({8'd3, 8'd2, 8'd1}, 1'b1);
        wait_idle();

        // All-ones tile, back-to-back stream
        load_tile({9{8'h01}});
        for (int v = 0; v < 4; v++) drive_vec(stream_v[v], v == 3);
        wait_idle();

        // Same stream with a bubble between vectors 2 and 3
        for (int v = 0; v < 4; v++) begin
            if (v == 2) @(negedge clk);
            drive_vec(stream_v[v], v == 3);
        end
        wait_idle();

        // Tile offered throughout STREAM and DRAIN must be ignored
        for (int v = 0; v < 4; v++) begin
            drive_vec(stream_v[v], v == 3);
            if (v == 0) begin
                cfg_w_valid = 1'b1;
                cfg_w_data  = {9{8'h77}};
            end
        end
        wait_idle();
        chk("weight_after_stream", sa_weightin, {9{8'h01}});

        // Modulo-256 wrap
        load_tile({9{8'h10}});
        drive_vec(24'h00_00_10, 1'b1);
        wait_idle();
        load_tile({9{8'h55}});
        drive_vec({8'd1, 8'd1, 8'd1}, 1'b1);
        wait_idle();

        // Reset two cycles after the first handshake of a stream
        load_tile({9{8'h01}});
        for (int v = 0; v < 3; v++) drive_vec(stream_v[v], 1'b0);
        reset = 1'b1;
        sb.delete();
        exp_done_cyc = -1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_busy_done", {busy, done}, 0);
        chk("midrst_sa_datain", sa_datain, 0);
        chk("midrst_sa_weightin", sa_weightin, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tb_w = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("postrst_in_ready", in_ready, 0);
            chk("postrst_out_valid", {out_valid, done}, 0);
        end
        load_tile({9{8'h01}});
        drive_vec({8'd2, 8'd2, 8'd2}, 1'b1);
        wait_idle();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
